// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared definitions for the register transfer sequencer: select constants,
// op and state encodings, and the legal-operand check reused by the decoder.
package reg_xfer_ctrl_pkg;

  localparam int RX_DATA_W = 8;
  localparam int RX_SEL_W  = 8;

  localparam logic [RX_SEL_W-1:0] SEL_AL = 8'h01;
  localparam logic [RX_SEL_W-1:0] SEL_BL = 8'h02;
  localparam logic [RX_SEL_W-1:0] SEL_CL = 8'h04;
  localparam logic [RX_SEL_W-1:0] SEL_DL = 8'h08;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_SWAP = 2'b01,
    OP_LDI  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOV_X  = 3'd1,
    ST_LDI_W  = 3'd2,
    ST_CLR_W  = 3'd3,
    ST_SW_RDA = 3'd4,
    ST_SW_XFR = 3'd5,
    ST_SW_WRB = 3'd6,
    ST_FIN    = 3'd7
  } state_e;

  // One-hot alone is not enough: the select must name an implemented register.
  function automatic logic sel_legal(input logic [RX_SEL_W-1:0] sel);
    return (sel == SEL_AL) || (sel == SEL_BL) || (sel == SEL_CL) || (sel == SEL_DL);
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Micro-sequencer driving reg_file's single read and write ports for
// MOV / SWAP / LDI / CLR, with a valid/ready command interface.
//
// state     | meaning
// IDLE      | ready for a command
// MOV_X     | read src and write dst in the same cycle
// LDI_W     | write immediate to dst
// CLR_W     | write zero to dst
// SW_RDA    | read A into tmp
// SW_XFR    | read B, write it to A
// SW_WRB    | write tmp to B
// FIN       | done pulse, then back to IDLE
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int SEL_W  = RX_SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_dst,
  input  logic [SEL_W-1:0]  cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              reg_r,
  output logic [SEL_W-1:0]  reg_r_select,
  input  logic [DATA_W-1:0] reg_r_line,
  output logic              reg_w,
  output logic [SEL_W-1:0]  reg_w_select,
  output logic [DATA_W-1:0] reg_w_line
);

  state_e              r_state;
  state_e              w_next;
  op_e                 r_op;
  logic [SEL_W-1:0]    r_dst;
  logic [SEL_W-1:0]    r_src;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_tmp;
  logic                r_err;

  logic                w_accept;
  logic                w_legal;
  op_e                 w_op;

  assign w_op     = op_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  // src only matters for the two ops that read a register.
  assign w_legal  = sel_legal(cmd_dst) &&
                    (((w_op == OP_MOV) || (w_op == OP_SWAP)) ? sel_legal(cmd_src) : 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MOV;
      r_dst   <= '0;
      r_src   <= '0;
      r_imm   <= '0;
      r_tmp   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && !w_legal;
      if (w_accept) begin
        r_op  <= w_op;
        r_dst <= cmd_dst;
        r_src <= cmd_src;
        r_imm <= cmd_imm;
      end
      if (r_state == ST_SW_RDA) r_tmp <= reg_r_line;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) begin
          case (w_op)
            OP_MOV:  w_next = ST_MOV_X;
            OP_SWAP: w_next = ST_SW_RDA;
            OP_LDI:  w_next = ST_LDI_W;
            default: w_next = ST_CLR_W;
          endcase
        end
      end
      ST_MOV_X:  w_next = ST_FIN;
      ST_LDI_W:  w_next = ST_FIN;
      ST_CLR_W:  w_next = ST_FIN;
      ST_SW_RDA: w_next = ST_SW_XFR;
      ST_SW_XFR: w_next = ST_SW_WRB;
      ST_SW_WRB: w_next = ST_FIN;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_r        = 1'b0;
    reg_r_select = '0;
    reg_w        = 1'b0;
    reg_w_select = '0;
    reg_w_line   = '0;
    case (r_state)
      ST_MOV_X: begin
        reg_r        = 1'b1;
        reg_r_select = r_src;
        reg_w        = 1'b1;
        reg_w_select = r_dst;
        reg_w_line   = reg_r_line;
      end
      ST_LDI_W: begin
        reg_w        = 1'b1;
        reg_w_select = r_dst;
        reg_w_line   = r_imm;
      end
      ST_CLR_W: begin
        reg_w        = 1'b1;
        reg_w_select = r_dst;
      end
      ST_SW_RDA: begin
        reg_r        = 1'b1;
        reg_r_select = r_dst;
      end
      ST_SW_XFR: begin
        reg_r        = 1'b1;
        reg_r_select = r_src;
        reg_w        = 1'b1;
        reg_w_select = r_dst;
        reg_w_line   = reg_r_line;
      end
      ST_SW_WRB: begin
        reg_w        = 1'b1;
        reg_w_select = r_src;
        reg_w_line   = r_tmp;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done      = (r_state == ST_FIN);
  assign err       = r_err;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: small reg_file model plus a value-level reference
// of the four registers, directed scenarios followed by random commands.
module tb_reg_xfer_ctrl;
  import reg_xfer_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_dst, cmd_src, cmd_imm;
  logic       done, err, busy;
  logic       reg_r, reg_w;
  logic [7:0] reg_r_select, reg_w_select, reg_r_line, reg_w_line;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc[$];

  logic [7:0] rf [4] = '{default: 8'h00};
  logic [7:0] exp_rf [4] = '{default: 8'h00};

  always #5 clk = ~clk;

  reg_xfer_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .err(err), .busy(busy),
    .reg_r(reg_r), .reg_r_select(reg_r_select), .reg_r_line(reg_r_line),
    .reg_w(reg_w), .reg_w_select(reg_w_select), .reg_w_line(reg_w_line)
  );

  // reg_file: AL..DL on select bits 0..3, combinational read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && !reset) acc_cyc.push_back(cyc);
    if (reg_w)
      for (int i = 0; i < 4; i++)
        if (reg_w_select[i]) rf[i] <= reg_w_line;
  end

  always_comb begin
    reg_r_line = 8'h00;
    if (reg_r)
      for (int i = 0; i < 4; i++)
        if (reg_r_select[i]) reg_r_line = reg_r_line | rf[i];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    check("done_err_excl", {31'd0, done && err}, 32'd0);
    check("sel_no_strobe", {31'd0, (!reg_r && reg_r_select != 0) || (!reg_w && reg_w_select != 0)}, 32'd0);
  end

  function automatic int sel_idx(input logic [7:0] s);
    for (int k = 0; k < 4; k++)
      if (s == (8'h01 << k)) return k;
    return -1;
  endfunction

  function automatic logic [7:0] sel_of(input int k);
    return 8'h01 << k;
  endfunction

  // Drive one command, watch 6 cycles after accept, compare with the model.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] dst, input logic [7:0] src,
                        input logic [7:0] imm, input string tag);
    int  d, s, lat_exp, done_at, err_at, wcnt, rcnt, ndone, nerr, to;
    bit  legal;
    logic [7:0] t;
    d = sel_idx(dst);
    s = sel_idx(src);
    legal = (d >= 0) && (((op == 2'b00) || (op == 2'b01)) ? (s >= 0) : 1'b1);
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_valid = 1'b1;
    to = 0;
    while (!cmd_ready && to < 20) begin @(negedge clk); to++; end
    if (to >= 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    done_at = -1; err_at = -1; wcnt = 0; rcnt = 0; ndone = 0; nerr = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_dst = 8'($urandom); cmd_src = 8'($urandom); cmd_imm = 8'($urandom);
      end
      if (done) begin ndone++; if (done_at < 0) done_at = k; end
      if (err)  begin nerr++;  if (err_at  < 0) err_at  = k; end
      if (reg_w) wcnt++;
      if (reg_r) rcnt++;
    end
    if (legal) begin
      lat_exp = (op == 2'b01) ? 4 : 2;
      check({tag, "_done_lat"}, done_at, lat_exp);
      check({tag, "_ndone"}, ndone, 1);
      check({tag, "_nerr"}, nerr, 0);
      check({tag, "_wcnt"}, wcnt, (op == 2'b01) ? 2 : 1);
      check({tag, "_rcnt"}, rcnt, (op == 2'b00) ? 1 : (op == 2'b01) ? 2 : 0);
      case (op)
        2'b00: exp_rf[d] = exp_rf[s];
        2'b01: begin t = exp_rf[d]; exp_rf[d] = exp_rf[s]; exp_rf[s] = t; end
        2'b10: exp_rf[d] = imm;
        default: exp_rf[d] = 8'h00;
      endcase
    end else begin
      check({tag, "_err_at"}, err_at, 1);
      check({tag, "_nerr"}, nerr, 1);
      check({tag, "_ndone"}, ndone, 0);
      check({tag, "_wcnt"}, wcnt, 0);
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s_rf%0d", tag, i), rf[i], exp_rf[i]);
  endtask

  initial begin
    int n0, to;
    logic [7:0] rd, rs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 8'h00; cmd_src = 8'h00; cmd_imm = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {reg_r, reg_w}, 0);
    check("rst_sel", {reg_r_select, reg_w_select, reg_w_line}, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    do_cmd(2'b10, SEL_AL, 8'h00, 8'hAA, "ldi_al");
    do_cmd(2'b10, SEL_BL, 8'h00, 8'hBB, "ldi_bl");
    do_cmd(2'b00, SEL_CL, SEL_AL, 8'h00, "mov_cl_al");
    do_cmd(2'b00, SEL_CL, SEL_CL, 8'h00, "mov_same");
    do_cmd(2'b10, SEL_AL, 8'h00, 8'h11, "ldi_al11");
    do_cmd(2'b10, SEL_DL, 8'h00, 8'h22, "ldi_dl22");
    do_cmd(2'b01, SEL_AL, SEL_DL, 8'h00, "swap_al_dl");
    do_cmd(2'b01, SEL_BL, SEL_BL, 8'h00, "swap_same");
    do_cmd(2'b00, SEL_CL, 8'h03, 8'h00, "mov_bad_src");
    do_cmd(2'b11, 8'h10, 8'h00, 8'h00, "clr_bad_dst");

    // CLR then LDI with cmd_valid held: second accept three cycles later.
    n0 = acc_cyc.size();
    @(negedge clk);
    cmd_op = 2'b11; cmd_dst = SEL_BL; cmd_src = 8'h00; cmd_imm = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_op = 2'b10; cmd_imm = 8'h5A;
    to = 0;
    while (acc_cyc.size() < n0 + 2 && to < 20) begin @(negedge clk); to++; end
    check("b2b_accepts", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() >= n0 + 2) check("b2b_gap", acc_cyc[n0+1] - acc_cyc[n0], 3);
    check("b2b_bl_cleared", rf[1], 8'h00);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_bl_ldi", rf[1], 8'h5A);
    exp_rf[1] = 8'h5A;

    // Reset during SW_XFR: AL already took BL's value at that edge.
    do_cmd(2'b10, SEL_AL, 8'h00, 8'h33, "pre_al");
    do_cmd(2'b10, SEL_BL, 8'h00, 8'h44, "pre_bl");
    @(negedge clk);
    cmd_op = 2'b01; cmd_dst = SEL_AL; cmd_src = SEL_BL; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("xfr_reg_w", reg_w, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rrst_busy", busy, 0);
    check("rrst_done", done, 0);
    check("rrst_strobes", {reg_r, reg_w}, 0);
    check("rrst_outs", {reg_r_select, reg_w_select, reg_w_line}, 0);
    check("rrst_ready", cmd_ready, 1);
    reset = 1'b0;
    exp_rf[0] = 8'h44;
    check("rrst_bl_kept", rf[1], 8'h44);
    do_cmd(2'b10, SEL_CL, 8'h00, 8'h77, "post_rst_ldi");

    for (int n = 0; n < 60; n++) begin
      rd = ($urandom_range(0, 9) < 8) ? sel_of($urandom_range(0, 3)) : 8'($urandom);
      rs = ($urandom_range(0, 9) < 8) ? sel_of($urandom_range(0, 3)) : 8'($urandom);
      do_cmd(2'($urandom), rd, rs, 8'($urandom), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
